// File: rtl/result_tuple_packer_pkg.sv
// Shared constants and types for the result tuple packer.
//   TupleW   : width of one tuple lane in bits
//   InLanes  : tuple lanes per sparse input beat
//   OutLanes : tuple lanes per dense output beat
//   BufSlots : packing buffer depth in tuples (InLanes + OutLanes)
package result_tuple_packer_pkg;

  localparam int unsigned TupleW     = 64;
  localparam int unsigned InLanes    = 16;
  localparam int unsigned OutLanes   = 8;
  localparam int unsigned BufSlots   = InLanes + OutLanes;
  localparam int unsigned TupleBytes = TupleW / 8;
  localparam int unsigned InKeepW    = InLanes * TupleBytes;
  localparam int unsigned OutKeepW   = OutLanes * TupleBytes;

  typedef logic [TupleW-1:0] tuple_t;

endpackage

// File: rtl/tuple_lane_compactor.sv
// Combinational lane compactor: moves the masked-in tuples to the low lanes,
// preserving lane order, and reports how many there were.
//   tuples_i : Lanes tuples, lane i at [i*TupleW +: TupleW]
//   mask_i   : per-lane valid bit
//   packed_o : compacted tuples, first valid lane in lane 0, unused lanes zero
//   count_o  : number of valid lanes
module tuple_lane_compactor #(
  parameter int unsigned TupleW = 64,
  parameter int unsigned Lanes  = 16,
  parameter int unsigned PopW   = $clog2(Lanes + 1)
) (
  input  logic [Lanes*TupleW-1:0] tuples_i,
  input  logic [Lanes-1:0]        mask_i,
  output logic [Lanes*TupleW-1:0] packed_o,
  output logic [PopW-1:0]         count_o
);

  int unsigned pos;

  always_comb begin
    packed_o = '0;
    pos      = 0;
    for (int unsigned i = 0; i < Lanes; i++) begin
      if (mask_i[i]) begin
        packed_o[pos*TupleW +: TupleW] = tuples_i[i*TupleW +: TupleW];
        pos = pos + 1;
      end
    end
    count_o = PopW'(pos);
  end

endmodule

// File: rtl/result_tuple_packer.sv
// Packs sparse join-result beats (IN_LANES tuple lanes with byte keep) into
// dense OUT_LANES-tuple beats. Packet boundaries are preserved: the last beat
// of a packet may be partial, or empty (keep=0) for a packet with no tuples.
//   clk, rst               : clock, asynchronous active-high reset
//   in_data/in_keep        : sparse input beat; lane i valid iff in_keep[i*TUPLE_W/8]
//   in_valid/in_last       : input handshake and end-of-packet
//   in_ready               : input accepted when in_valid & in_ready
//   out_data/out_keep      : packed beat, keep contiguous from bit 0
//   out_valid/out_last     : output handshake and end-of-packet
//   out_ready              : downstream ready
module result_tuple_packer
  import result_tuple_packer_pkg::*;
#(
  parameter int unsigned TUPLE_W   = TupleW,
  parameter int unsigned IN_LANES  = InLanes,
  parameter int unsigned OUT_LANES = OutLanes
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [IN_LANES*TUPLE_W-1:0]      in_data,
  input  logic [IN_LANES*TUPLE_W/8-1:0]    in_keep,
  input  logic                             in_valid,
  input  logic                             in_last,
  output logic                             in_ready,
  output logic [OUT_LANES*TUPLE_W-1:0]     out_data,
  output logic [OUT_LANES*TUPLE_W/8-1:0]   out_keep,
  output logic                             out_valid,
  output logic                             out_last,
  input  logic                             out_ready
);

  localparam int unsigned BUF_SLOTS = IN_LANES + OUT_LANES;
  localparam int unsigned TUPLE_B   = TUPLE_W / 8;
  localparam int unsigned CNT_W     = $clog2(BUF_SLOTS + 1);
  localparam int unsigned IDX_W     = $clog2(BUF_SLOTS);
  localparam int unsigned POP_W     = $clog2(IN_LANES + 1);
  localparam logic [CNT_W-1:0] OutCnt = CNT_W'(OUT_LANES);

  logic [TUPLE_W-1:0]          slot_q [BUF_SLOTS];
  logic [TUPLE_W-1:0]          slot_d [BUF_SLOTS];
  logic [CNT_W-1:0]            count_q, count_d;
  logic                        flush_q, flush_d;
  logic                        empty_last_q, empty_last_d;

  logic [IN_LANES-1:0]         lane_mask;
  logic [IN_LANES*TUPLE_W-1:0] comp_data;
  logic [POP_W-1:0]            comp_cnt;
  logic                        emit, accept;
  logic [CNT_W-1:0]            n_emit, base;
  int unsigned                 tgt;
  logic                        unused_keep;

  // Only the first keep byte of each lane carries meaning.
  always_comb begin
    for (int unsigned i = 0; i < IN_LANES; i++) begin
      lane_mask[i] = in_keep[i*TUPLE_B];
    end
  end
  assign unused_keep = ^in_keep;

  tuple_lane_compactor #(
    .TupleW (TUPLE_W),
    .Lanes  (IN_LANES),
    .PopW   (POP_W)
  ) u_compactor (
    .tuples_i (in_data),
    .mask_i   (lane_mask),
    .packed_o (comp_data),
    .count_o  (comp_cnt)
  );

  // Outputs depend on registered state only.
  assign in_ready  = !flush_q && !empty_last_q && (count_q <= OutCnt);
  assign out_valid = (count_q >= OutCnt) || (flush_q && (count_q != '0)) || empty_last_q;
  assign out_last  = (flush_q && (count_q <= OutCnt)) || empty_last_q;

  always_comb begin
    for (int unsigned l = 0; l < OUT_LANES; l++) begin
      out_data[l*TUPLE_W +: TUPLE_W] = slot_q[l];
    end
    for (int unsigned b = 0; b < OUT_LANES * TUPLE_B; b++) begin
      out_keep[b] = ((b / TUPLE_B) < 32'(count_q));
    end
  end

  always_comb begin
    slot_d       = slot_q;
    flush_d      = flush_q;
    empty_last_d = empty_last_q;
    tgt          = 0;
    emit         = out_valid && out_ready;
    accept       = in_valid && in_ready;
    n_emit       = '0;
    if (emit) begin
      n_emit = (count_q >= OutCnt) ? OutCnt : count_q;
    end
    // Shift out the emitted beat first; accepted tuples append after what remains.
    if (emit) begin
      for (int unsigned j = 0; j < BUF_SLOTS; j++) begin
        tgt = j + 32'(n_emit);
        if (tgt < BUF_SLOTS) begin
          slot_d[j] = slot_q[IDX_W'(tgt)];
        end
      end
    end
    base = count_q - n_emit;
    if (accept) begin
      for (int unsigned k = 0; k < IN_LANES; k++) begin
        tgt = 32'(base) + k;
        if ((k < 32'(comp_cnt)) && (tgt < BUF_SLOTS)) begin
          slot_d[IDX_W'(tgt)] = comp_data[k*TUPLE_W +: TUPLE_W];
        end
      end
    end
    count_d = base + (accept ? CNT_W'(comp_cnt) : '0);
    if (emit && out_last) begin
      flush_d      = 1'b0;
      empty_last_d = 1'b0;
    end
    // in_ready is low while a flag is set, so set and clear never collide.
    if (accept && in_last) begin
      if (count_d != '0) begin
        flush_d = 1'b1;
      end else begin
        empty_last_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q      <= '0;
      flush_q      <= 1'b0;
      empty_last_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      flush_q      <= flush_d;
      empty_last_q <= empty_last_d;
    end
  end

  // Buffer contents are don't-care after reset.
  always_ff @(posedge clk) begin
    slot_q <= slot_d;
  end

  // Accepting only at count <= OUT_LANES keeps the buffer from overflowing.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      assert (32'(base) + 32'(comp_cnt) <= BUF_SLOTS);
    end
  end

endmodule

// File: tb/tb_result_tuple_packer.sv
module tb_result_tuple_packer;
  import result_tuple_packer_pkg::*;

  localparam int unsigned TW  = 64;
  localparam int unsigned IL  = 16;
  localparam int unsigned OL  = 8;
  localparam int unsigned BPL = TW / 8;
  localparam int unsigned IKW = IL * BPL;
  localparam int unsigned OKW = OL * BPL;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [IL*TW-1:0]  in_data = '0;
  logic [IKW-1:0]    in_keep = '0;
  logic              in_valid = 1'b0;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic [OL*TW-1:0]  out_data;
  logic [OKW-1:0]    out_keep;
  logic              out_valid;
  logic              out_last;
  logic              out_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  int bp_mode = 0;  // 0: always ready, 1: random 50%, 2: never ready

  // Reference model: expected tuple stream and per-packet tuple counts.
  tuple_t exp_q[$];
  int     pkt_q[$];
  int     pkt_acc = 0;
  int     popped = 0;

  // Log of fired output beats for the directed checks.
  int             obs_n[$];
  bit             obs_last[$];
  logic [OKW-1:0] obs_keep[$];

  bit             prev_stall = 0;
  logic [OL*TW-1:0] prev_data;
  logic [OKW-1:0] prev_keep;
  logic           prev_last;

  result_tuple_packer dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_keep   (in_keep),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    case (bp_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every fired beat must be a contiguous prefix of the expected stream.
  int             mon_n;
  logic [OKW-1:0] mon_keep;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
      popped     = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 512'(out_valid), 512'(1));
        chk("stall_data", out_data, prev_data);
        chk("stall_keep", 512'(out_keep), 512'(prev_keep));
        chk("stall_last", 512'(out_last), 512'(prev_last));
      end
      if (out_valid && out_ready) begin
        mon_n = 0;
        for (int l = 0; l < int'(OL); l++) if (out_keep[l*BPL] && mon_n == l) mon_n++;
        mon_keep = '0;
        for (int b = 0; b < mon_n * int'(BPL); b++) mon_keep[b] = 1'b1;
        chk("keep_contig", 512'(out_keep), 512'(mon_keep));
        if (!out_last) chk("full_beat", 512'(mon_n), 512'(OL));
        for (int l = 0; l < mon_n; l++) begin
          checks++;
          assert (exp_q.size() > 0) else begin
            errors++;
            $error("FAIL tuple_extra: observed=%0h expected=none", out_data[l*TW +: TW]);
          end
          if (exp_q.size() > 0) chk("tuple", 512'(out_data[l*TW +: TW]), 512'(exp_q.pop_front()));
          popped++;
        end
        if (out_last) begin
          checks++;
          assert (pkt_q.size() > 0) else begin
            errors++;
            $error("FAIL pkt_extra: observed=out_last expected=no packet pending");
          end
          if (pkt_q.size() > 0) chk("pkt_size", 512'(popped), 512'(pkt_q.pop_front()));
          popped = 0;
        end
        obs_n.push_back(mon_n);
        obs_last.push_back(out_last);
        obs_keep.push_back(out_keep);
        prev_stall = 0;
      end else if (out_valid) begin
        prev_stall = 1;
        prev_data  = out_data;
        prev_keep  = out_keep;
        prev_last  = out_last;
      end else begin
        prev_stall = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [IL-1:0] mask, input bit last);
    int cyc = 0;
    bit acc = 0;
    tuple_t t;
    for (int l = 0; l < int'(IL); l++) begin
      t = {$urandom, $urandom};
      in_data[l*TW +: TW] = t;
      in_keep[l*BPL +: BPL] = {7'($urandom), mask[l]};
      if (mask[l]) begin
        exp_q.push_back(t);
        pkt_acc++;
      end
    end
    if (last) begin
      pkt_q.push_back(pkt_acc);
      pkt_acc = 0;
    end
    in_last  = last;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      cyc++;
    end while (!acc && cyc < 2000);
    checks++;
    assert (acc) else begin
      errors++;
      $error("FAIL in_accept_timeout: observed=not accepted expected=accepted");
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain(input string tag);
    int cyc = 0;
    while ((exp_q.size() != 0 || pkt_q.size() != 0) && cyc < 5000) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    chk(tag, 512'(exp_q.size() + pkt_q.size()), 512'(0));
  endtask

  task automatic clear_obs();
    obs_n.delete();
    obs_last.delete();
    obs_keep.delete();
  endtask

  initial begin
    logic [IL-1:0] m;
    int r, lasts;

    // Reset state.
    repeat (2) tick();
    @(negedge clk);
    chk("rst_in_ready", 512'(in_ready), 512'(1));
    chk("rst_out_valid", 512'(out_valid), 512'(0));
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk("idle_out_valid", 512'(out_valid), 512'(0));
    chk("idle_out_last", 512'(out_last), 512'(0));
    chk("idle_out_keep", 512'(out_keep), 512'(0));
    chk("idle_in_ready", 512'(in_ready), 512'(1));
    tick();

    // Two full beats, last on the second -> four full beats, last on the fourth.
    bp_mode = 0;
    repeat (2) tick();
    clear_obs();
    send_beat(16'hFFFF, 0);
    send_beat(16'hFFFF, 1);
    drain("d1_drain");
    chk("d1_beats", 512'(obs_n.size()), 512'(4));
    for (int i = 0; i < 4; i++) begin
      chk("d1_keep", 512'(obs_keep[i]), 512'({OKW{1'b1}}));
      chk("d1_last", 512'(obs_last[i]), 512'(i == 3));
    end

    // Lanes 1,3,4,9,15 -> one 5-tuple beat.
    clear_obs();
    send_beat(16'h821A, 1);
    drain("d2_drain");
    chk("d2_beats", 512'(obs_n.size()), 512'(1));
    chk("d2_keep", 512'(obs_keep[0]), 512'(64'h0000_00FF_FFFF_FFFF));
    chk("d2_last", 512'(obs_last[0]), 512'(1));

    // 5 lanes then 7 lanes + last -> 8 then 4 tuples.
    clear_obs();
    send_beat(16'h0F01, 0);
    send_beat(16'h7F00, 1);
    drain("d3_drain");
    chk("d3_beats", 512'(obs_n.size()), 512'(2));
    chk("d3_keep0", 512'(obs_keep[0]), 512'({OKW{1'b1}}));
    chk("d3_keep1", 512'(obs_keep[1]), 512'(64'h0000_0000_FFFF_FFFF));
    chk("d3_last0", 512'(obs_last[0]), 512'(0));
    chk("d3_last1", 512'(obs_last[1]), 512'(1));

    // Empty packet at idle -> one keep=0 beat with last; input blocked until it fires.
    bp_mode = 2;
    repeat (2) tick();
    clear_obs();
    send_beat(16'h0000, 1);
    @(negedge clk);
    chk("d4_in_ready", 512'(in_ready), 512'(0));
    chk("d4_out_valid", 512'(out_valid), 512'(1));
    chk("d4_out_keep", 512'(out_keep), 512'(0));
    chk("d4_out_last", 512'(out_last), 512'(1));
    bp_mode = 0;
    drain("d4_drain");
    chk("d4_beats", 512'(obs_n.size()), 512'(1));
    chk("d4_obs_keep", 512'(obs_keep[0]), 512'(0));
    @(negedge clk);
    chk("d4_in_ready_after", 512'(in_ready), 512'(1));
    tick();

    // Randomized packets under 50% backpressure.
    bp_mode = 1;
    clear_obs();
    for (int p = 0; p < 10; p++) begin
      for (int b = 0; b < 100; b++) begin
        r = $urandom_range(0, 5);
        case (r)
          0:       m = 16'h0000;
          1:       m = 16'hFFFF;
          default: m = IL'($urandom);
        endcase
        send_beat(m, b == 99);
        r = $urandom_range(0, 1);
        if (r > 0) tick();
      end
    end
    drain("rnd_drain");
    lasts = 0;
    foreach (obs_last[i]) if (obs_last[i]) lasts++;
    chk("rnd_lasts", 512'(lasts), 512'(10));

    // Reset mid-packet with 12 tuples buffered.
    bp_mode = 2;
    repeat (2) tick();
    send_beat(16'h0FFF, 0);
    @(negedge clk);
    chk("rst12_out_valid", 512'(out_valid), 512'(1));
    chk("rst12_in_ready", 512'(in_ready), 512'(0));
    tick();
    rst = 1'b1;
    exp_q.delete();
    pkt_acc = 0;
    @(negedge clk);
    chk("rst_async_out_valid", 512'(out_valid), 512'(0));
    chk("rst_async_in_ready", 512'(in_ready), 512'(1));
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_out_valid", 512'(out_valid), 512'(0));
    chk("post_rst_in_ready", 512'(in_ready), 512'(1));
    bp_mode = 1;
    tick();
    clear_obs();
    send_beat(16'hA5C3, 0);
    send_beat(16'h0F0F, 1);
    drain("post_rst_drain");
    chk("post_rst_beats", 512'(obs_n.size()), 512'(2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
